pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 8-bit, 4-register, 5-stage core. It drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves load-use hazards and taken-branch flushes.
- Freezes the pipeline while data memory (including stack push/pop) is not ready.
- Sequences interrupt entry by draining in-flight instructions before vectoring.

It also keeps a saturating stall counter and a sticky memory-timeout flag.

## Interface
Parameters:
- WAIT_MAX, 15, max consecutive MEM_WAIT cycles before timeout (1..255)
- DRAIN_CYCLES, 3, progress cycles spent draining before interrupt vector (1..7)
- CNT_W, 16, width of stall_cnt

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs_a, id_rs_b  in  2 each  source registers of instruction in ID
- id_rs_a_used, id_rs_b_used  in  1 each  source operand actually read
- ex_mem_read  in  1  instruction in EX is a load or stack pop
- ex_rd  in  2  destination of instruction in EX
- ex_branch_taken  in  1  branch/jump/call resolved taken in EX
- mem_access  in  1  instruction in MEM accesses data memory (load/store/push/pop)
- mem_ready  in  1  data memory completes access this cycle
- irq  in  1  level-sensitive interrupt request
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID load enable
- pipe_en  out  1  ID/EX and EX/MEM load enable
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  insert bubble
- irq_ack  out  1  one-cycle interrupt acknowledge
- vec_sel  out  1  PC mux selects interrupt vector
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0
- mem_err  out  1  sticky memory timeout

## Operation
- States: RUN, MEM_WAIT, IRQ_DRAIN, IRQ_VEC. Control outputs are Mealy (state + inputs). stall_cnt and mem_err are registered.
- Default outputs (no condition active): pc_en=1, if_id_en=1, pipe_en=1, all flushes 0, irq_ack=0, vec_sel=0.
- Priority in RUN, highest first:
  1. Memory stall: mem_access && !mem_ready gives pc_en=if_id_en=pipe_en=0 and mem_wb_flush=1; next state MEM_WAIT.
  2. Branch: ex_branch_taken gives if_id_flush=1 and id_ex_flush=1; pc_en=1 (target load).
  3. Load-use: ex_mem_read && ((id_rs_a_used && id_rs_a==ex_rd) || (id_rs_b_used && id_rs_b==ex_rd)) gives pc_en=0, if_id_en=0, id_ex_flush=1.
  4. Interrupt: irq gives pc_en=0 and if_id_flush=1; drain counter loads DRAIN_CYCLES-1; next state IRQ_DRAIN.
- MEM_WAIT: same outputs as the memory stall. A wait counter increments each cycle.
  - On mem_ready: default outputs, return to RUN, counter cleared.
  - When the counter reaches WAIT_MAX with no ready: mem_err is set, the controller releases (default outputs) and returns to RUN.
- IRQ_DRAIN: pc_en=0, if_id_flush=1.
  - A memory stall holds the drain counter and applies the stall outputs.
  - ex_branch_taken adds id_ex_flush=1 and pc_en=1 (target becomes the return address).
  - Load-use is ignored (ID holds a bubble).
  - The counter decrements on non-stalled cycles; at 0 the next state is IRQ_VEC.
- IRQ_VEC: irq_ack=1, vec_sel=1, pc_en=1, if_id_flush=1 for one cycle, then RUN. A memory stall here delays the cycle (stall outputs, irq_ack=0).
- irq is sampled only in RUN. irq still high after IRQ_VEC re-enters only via priority 4 in RUN.
- stall_cnt increments on every cycle with pc_en=0 and saturates at all-ones.

## Timing
- Reset (asynchronous, while rst=1): state=RUN and counters 0.
  - Outputs: pc_en=0, if_id_en=0, pipe_en=0, all four flushes=1, irq_ack=0, vec_sel=0, stall_cnt=0, mem_err=0.
- Control outputs have zero latency from inputs; state changes on the clk rising edge.
- Load-use costs exactly 1 bubble, taken branch costs 2 bubbles, and interrupt entry costs DRAIN_CYCLES+1 fetch-free cycles plus any memory stalls.
- mem_err rises on the edge ending cycle WAIT_MAX of MEM_WAIT and is cleared only by rst.
- rst asserted mid-MEM_WAIT or mid-IRQ_DRAIN aborts immediately; no irq_ack is issued.

## Configuration
- HAZ_IRQ_EN defined: IRQ_DRAIN/IRQ_VEC and the drain counter are built, and behaviour is as above.
- HAZ_IRQ_EN undefined: irq is ignored, irq_ack=vec_sel=0 constant, and only RUN/MEM_WAIT exist. DRAIN_CYCLES is unused.

## Test plan
- ex_mem_read=1, ex_rd=2, id_rs_a=2, id_rs_a_used=1 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt 0->1.
- Same cycle ex_branch_taken=1 plus a load-use match -> if_id_flush=id_ex_flush=1, pc_en=1 (branch wins).
- mem_access=1, mem_ready=0 for 4 cycles, then ready -> 4 cycles pipe_en=0, mem_wb_flush=1; 5th cycle defaults; mem_err=0.
- mem_ready held 0 with WAIT_MAX=15 -> mem_err=1 after cycle 15, controller back in RUN and stays sticky until rst.
- irq=1 in RUN, DRAIN_CYCLES=3, one memory stall during drain -> irq_ack pulses exactly once, 5 cycles after irq is sampled, with vec_sel=1.
- Build without HAZ_IRQ_EN and drive irq=1 for 10 cycles -> irq_ack stays 0 and pc_en stays 1.

Source files
------------

// File: rtl/pipe_hazard_if.sv
// Pipeline-side bundle of the hazard controller: hazard inputs from ID/EX/MEM
// and the enable/flush/vector controls back to the pipeline registers.
interface pipe_hazard_if #(
    parameter int CNT_W = 16
);
    logic [1:0]       id_rs_a;
    logic [1:0]       id_rs_b;
    logic             id_rs_a_used;
    logic             id_rs_b_used;
    logic             ex_mem_read;
    logic [1:0]       ex_rd;
    logic             ex_branch_taken;
    logic             mem_access;
    logic             mem_ready;
    logic             irq;

    logic             pc_en;
    logic             if_id_en;
    logic             pipe_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             mem_wb_flush;
    logic             irq_ack;
    logic             vec_sel;
    logic [CNT_W-1:0] stall_cnt;
    logic             mem_err;

    // master = the controller, slave = the pipeline it steers
    modport master (
        input  id_rs_a, id_rs_b, id_rs_a_used, id_rs_b_used, ex_mem_read, ex_rd,
               ex_branch_taken, mem_access, mem_ready, irq,
        output pc_en, if_id_en, pipe_en, if_id_flush, id_ex_flush, ex_mem_flush,
               mem_wb_flush, irq_ack, vec_sel, stall_cnt, mem_err
    );

    modport slave (
        output id_rs_a, id_rs_b, id_rs_a_used, id_rs_b_used, ex_mem_read, ex_rd,
               ex_branch_taken, mem_access, mem_ready, irq,
        input  pc_en, if_id_en, pipe_en, if_id_flush, id_ex_flush, ex_mem_flush,
               mem_wb_flush, irq_ack, vec_sel, stall_cnt, mem_err
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: load-use, branch flush,
// memory freeze with timeout, and interrupt drain/vector (built with HAZ_IRQ_EN).
module pipe_hazard_ctrl #(
    parameter int WAIT_MAX     = 15,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic          clk,
    input  logic          rst,
    pipe_hazard_if.master bus
);
    if (WAIT_MAX < 1 || WAIT_MAX > 255 || DRAIN_CYCLES < 1 || DRAIN_CYCLES > 7) begin : g_bad_param
        $error("pipe_hazard_ctrl: WAIT_MAX or DRAIN_CYCLES out of range");
    end

`ifdef HAZ_IRQ_EN
    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, IRQ_DRAIN = 2'd2, IRQ_VEC = 2'd3} state_t;
`else
    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1} state_t;
`endif

    state_t           state, state_nx;
    logic [7:0]       wait_cnt, wait_cnt_nx;
    logic [CNT_W-1:0] stall_q;
    logic             err_q;
    logic             err_set;
    logic             frz;
    logic             mem_stall;
    logic             load_use;

`ifdef HAZ_IRQ_EN
    logic [2:0]       drain_cnt, drain_cnt_nx;
`else
    logic             unused_irq;
    assign unused_irq = bus.irq;
`endif

    assign mem_stall = bus.mem_access & ~bus.mem_ready;
    assign load_use  = bus.ex_mem_read &
                       ((bus.id_rs_a_used && bus.id_rs_a == bus.ex_rd) ||
                        (bus.id_rs_b_used && bus.id_rs_b == bus.ex_rd));

    always_comb begin
        state_nx         = state;
        wait_cnt_nx      = wait_cnt;
        err_set          = 1'b0;
        frz              = 1'b0;
`ifdef HAZ_IRQ_EN
        drain_cnt_nx     = drain_cnt;
`endif
        bus.pc_en        = 1'b1;
        bus.if_id_en     = 1'b1;
        bus.pipe_en      = 1'b1;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_flush  = 1'b0;
        bus.ex_mem_flush = 1'b0;
        bus.mem_wb_flush = 1'b0;
        bus.irq_ack      = 1'b0;
        bus.vec_sel      = 1'b0;
        if (rst) begin
            // whole pipe held empty while in reset
            bus.pc_en        = 1'b0;
            bus.if_id_en     = 1'b0;
            bus.pipe_en      = 1'b0;
            bus.if_id_flush  = 1'b1;
            bus.id_ex_flush  = 1'b1;
            bus.ex_mem_flush = 1'b1;
            bus.mem_wb_flush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        frz         = 1'b1;
                        state_nx    = MEM_WAIT;
                        wait_cnt_nx = '0;
                    end else if (bus.ex_branch_taken) begin
                        bus.if_id_flush = 1'b1;
                        bus.id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        bus.pc_en       = 1'b0;
                        bus.if_id_en    = 1'b0;
                        bus.id_ex_flush = 1'b1;
                    end
`ifdef HAZ_IRQ_EN
                    else if (bus.irq) begin
                        bus.pc_en       = 1'b0;
                        bus.if_id_flush = 1'b1;
                        drain_cnt_nx    = 3'(DRAIN_CYCLES - 1);
                        state_nx        = IRQ_DRAIN;
                    end
`endif
                end
                MEM_WAIT: begin
                    if (bus.mem_ready) begin
                        state_nx    = RUN;
                        wait_cnt_nx = '0;
                    end else if (wait_cnt == 8'(WAIT_MAX - 1)) begin
                        // give up on the access and let the pipe move again
                        err_set     = 1'b1;
                        state_nx    = RUN;
                        wait_cnt_nx = '0;
                    end else begin
                        frz         = 1'b1;
                        wait_cnt_nx = wait_cnt + 8'd1;
                    end
                end
`ifdef HAZ_IRQ_EN
                IRQ_DRAIN: begin
                    bus.pc_en       = 1'b0;
                    bus.if_id_flush = 1'b1;
                    if (mem_stall) begin
                        frz = 1'b1;
                    end else begin
                        // taken branch while draining retargets the return address
                        if (bus.ex_branch_taken) begin
                            bus.id_ex_flush = 1'b1;
                            bus.pc_en       = 1'b1;
                        end
                        if (drain_cnt == 3'd0) state_nx = IRQ_VEC;
                        else drain_cnt_nx = drain_cnt - 3'd1;
                    end
                end
                IRQ_VEC: begin
                    if (mem_stall) begin
                        frz = 1'b1;
                    end else begin
                        bus.irq_ack     = 1'b1;
                        bus.vec_sel     = 1'b1;
                        bus.if_id_flush = 1'b1;
                        state_nx        = RUN;
                    end
                end
`endif
                default: state_nx = RUN;
            endcase
            if (frz) begin
                bus.pc_en        = 1'b0;
                bus.if_id_en     = 1'b0;
                bus.pipe_en      = 1'b0;
                bus.mem_wb_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            stall_q  <= '0;
            err_q    <= 1'b0;
`ifdef HAZ_IRQ_EN
            drain_cnt <= '0;
`endif
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
`ifdef HAZ_IRQ_EN
            drain_cnt <= drain_cnt_nx;
`endif
            if (!bus.pc_en && stall_q != '1) stall_q <= stall_q + 1'b1;
            if (err_set) err_q <= 1'b1;
        end
    end

    assign bus.stall_cnt = stall_q;
    assign bus.mem_err   = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized scoreboard bench for pipe_hazard_ctrl with a cycle-level reference
// model; follows HAZ_IRQ_EN the same way as the design.
module tb_pipe_hazard_ctrl;
    localparam int WAIT_MAX     = 15;
    localparam int DRAIN_CYCLES = 3;
    localparam int CNT_W        = 6;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;
    localparam int M_RUN = 0, M_WAIT = 1, M_DRAIN = 2, M_VEC = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_if #(.CNT_W(CNT_W)) bus();

    pipe_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic             pc;
        logic             ifid;
        logic             pipe;
        logic [3:0]       fl;   // {if_id, id_ex, ex_mem, mem_wb}
        logic             ack;
        logic             vec;
        logic [CNT_W-1:0] cnt;
        logic             err;
    } obs_t;

    obs_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc_no     = 0;

    // reference model state
    int   mode       = M_RUN;
    int   waited     = 0;
    int   drain_left = 0;
    int   m_cnt      = 0;
    bit   m_err      = 1'b0;

    task automatic step(input bit r, input logic [1:0] ra, input logic [1:0] rb,
                        input bit au, input bit bu, input bit mr, input logic [1:0] rd,
                        input bit br, input bit macc, input bit mrdy, input bit iq);
        obs_t e;
        bit   sst;
        bit   lu;
        bit   frz;
        @(negedge clk);
        rst                 = r;
        bus.id_rs_a         = ra;
        bus.id_rs_b         = rb;
        bus.id_rs_a_used    = au;
        bus.id_rs_b_used    = bu;
        bus.ex_mem_read     = mr;
        bus.ex_rd           = rd;
        bus.ex_branch_taken = br;
        bus.mem_access      = macc;
        bus.mem_ready       = mrdy;
        bus.irq             = iq;

        sst = macc && !mrdy;
        lu  = mr && ((au && ra == rd) || (bu && rb == rd));
        frz = 1'b0;
        e      = '0;
        e.pc   = 1'b1;
        e.ifid = 1'b1;
        e.pipe = 1'b1;
        if (r) begin
            e.pc = 1'b0; e.ifid = 1'b0; e.pipe = 1'b0; e.fl = 4'hF;
            mode = M_RUN; waited = 0; drain_left = 0; m_cnt = 0; m_err = 1'b0;
        end else begin
            e.cnt = CNT_W'(m_cnt);
            e.err = m_err;
            if (mode == M_RUN) begin
                if (sst) begin
                    frz = 1'b1; mode = M_WAIT; waited = 0;
                end else if (br) begin
                    e.fl[3] = 1'b1; e.fl[2] = 1'b1;
                end else if (lu) begin
                    e.pc = 1'b0; e.ifid = 1'b0; e.fl[2] = 1'b1;
                end
`ifdef HAZ_IRQ_EN
                else if (iq) begin
                    e.pc = 1'b0; e.fl[3] = 1'b1;
                    drain_left = DRAIN_CYCLES; mode = M_DRAIN;
                end
`endif
            end else if (mode == M_WAIT) begin
                waited++;
                if (mrdy) mode = M_RUN;
                else if (waited == WAIT_MAX) begin
                    m_err = 1'b1; mode = M_RUN;
                end else frz = 1'b1;
            end else if (mode == M_DRAIN) begin
                e.pc = 1'b0; e.fl[3] = 1'b1;
                if (sst) frz = 1'b1;
                else begin
                    if (br) begin
                        e.pc = 1'b1; e.fl[2] = 1'b1;
                    end
                    drain_left--;
                    if (drain_left == 0) mode = M_VEC;
                end
            end else begin
                if (sst) frz = 1'b1;
                else begin
                    e.ack = 1'b1; e.vec = 1'b1; e.fl[3] = 1'b1;
                    mode = M_RUN;
                end
            end
            if (frz) begin
                e.pc = 1'b0; e.ifid = 1'b0; e.pipe = 1'b0; e.fl[0] = 1'b1;
            end
            if (!e.pc && m_cnt < CNT_MAX) m_cnt++;
        end
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 2'd0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 1, 0);
    endtask

    // monitor: every cycle the DUT presents a full output vector
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = {bus.pc_en, bus.if_id_en, bus.pipe_en,
                     {bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mem_wb_flush},
                     bus.irq_ack, bus.vec_sel, bus.stall_cnt, bus.mem_err};
                compared++;
                if (a !== e) begin
                    mismatched++;
                    $display("FAIL outputs cyc %0d: got pc/ifid/pipe=%b%b%b fl=%b ack=%b vec=%b cnt=%0d err=%b, want pc/ifid/pipe=%b%b%b fl=%b ack=%b vec=%b cnt=%0d err=%b",
                             cyc_no, a.pc, a.ifid, a.pipe, a.fl, a.ack, a.vec, a.cnt, a.err,
                             e.pc, e.ifid, e.pipe, e.fl, e.ack, e.vec, e.cnt, e.err);
                end
                cyc_no++;
            end
        end
    end

    initial begin
        bit r, au, bu, mr, br, macc, mrdy, iq;
        logic [1:0] ra, rb, rd;
        int guard;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        // load-use on rs_a, then branch beating a load-use match
        step(0, 2'd2, 2'd0, 1, 0, 1, 2'd2, 0, 0, 1, 0);
        idle(1);
        step(0, 2'd2, 2'd1, 1, 1, 1, 2'd2, 1, 0, 1, 0);
        step(0, 2'd0, 2'd3, 0, 1, 1, 2'd3, 0, 0, 1, 0);
        idle(1);
        // short memory stall released by ready
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        idle(2);
        // memory timeout
        for (int k = 0; k < WAIT_MAX + 1; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(3);
        // interrupt entry with one memory stall during drain
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(5);
        // irq held high for 10 cycles
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(4);
        // reset mid memory wait
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(2);
        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            r    = ($urandom_range(299) == 0);
            ra   = 2'($urandom); rb = 2'($urandom); rd = 2'($urandom);
            au   = 1'($urandom); bu = 1'($urandom);
            mr   = ($urandom_range(1) == 0);
            br   = ($urandom_range(6) == 0);
            macc = ($urandom_range(2) == 0);
            mrdy = ($urandom_range(9) < 7);
            iq   = ($urandom_range(9) == 0);
            step(r, ra, rb, au, bu, mr, rd, br, macc, mrdy, iq);
        end
        idle(1);
        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            mismatched++;
            $display("FAIL drain: %0d entries left in scoreboard, want 0", sb.size());
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
